usb1_ctrl_host: RTL and testbench

USB1_CTRL_HOST -- requirements
Module: usb1_ctrl_host

---
 rtl/usb1_ctrl_host.sv | 226 ++++++++++++++++++++++
 tb/tb_usb1_ctrl_host.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb1_ctrl_host.sv
// USB 1.1 control-transfer host sequencer: SETUP, optional IN/OUT data stage, status handshake.
// Optional per-stage watchdog enabled by defining USB1_CTRL_HOST_TIMEOUT_EN.
module usb1_ctrl_host #(
  parameter int MAX_PKT    = 8,
  parameter int TMO_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  bmRequestType,
  input  logic [7:0]  bRequest,
  input  logic [15:0] wValue,
  input  logic [15:0] wIndex,
  input  logic [15:0] wLength,
  output logic        ctrl_setup,
  output logic        ctrl_in,
  output logic        ctrl_out,
  output logic [7:0]  tx_data,
  output logic        tx_we,
  input  logic        tx_full,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rx_re,
  input  logic        dev_ack,
  input  logic        dev_stall,
  input  logic [7:0]  wr_data,
  output logic        wr_re,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic [1:0]  status
);

  typedef enum logic [3:0] {
    IDLE, SETUP_TOK, SETUP_DAT, DIN_TOK, DIN_DAT,
    DOUT_TOK, DOUT_DAT, STAT_TOK, STAT_WAIT, FIN
  } state_t;

  localparam logic [15:0] MAX_PKT16 = 16'(MAX_PKT);

  state_t      state, state_nx;
  logic [7:0]  bm_q, breq_q;
  logic [15:0] wval_q, widx_q, wlen_q;
  logic [2:0]  idx;
  logic [15:0] rem;
  logic [6:0]  pkt_left;
  logic [7:0]  setup_byte;
  logic        dir_in;
  logic        stall_hit;
  logic        tmo_hit;
  logic        accept;

  assign accept = req_valid && req_ready;
  // Status stage direction depends on whether an IN data stage actually ran.
  assign dir_in = bm_q[7] && (wlen_q != 16'd0);

  always_comb begin
    setup_byte = 8'h00;
    case (idx)
      3'd0: setup_byte = bm_q;
      3'd1: setup_byte = breq_q;
      3'd2: setup_byte = wval_q[7:0];
      3'd3: setup_byte = wval_q[15:8];
      3'd4: setup_byte = widx_q[7:0];
      3'd5: setup_byte = widx_q[15:8];
      3'd6: setup_byte = wlen_q[7:0];
      3'd7: setup_byte = wlen_q[15:8];
      default: setup_byte = 8'h00;
    endcase
  end

`ifdef USB1_CTRL_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_en;

  assign tmo_en  = (state == SETUP_DAT) || (state == DIN_DAT) ||
                   (state == DOUT_DAT)  || (state == STAT_WAIT);
  assign tmo_hit = tmo_en && (tmo_cnt == TW'(TMO_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                   tmo_cnt <= '0;
    else if (state_nx != state) tmo_cnt <= '0;
    else if (tmo_en)           tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  // Watchdog absent: this term is constant false for any legal TMO_CYCLES.
  assign tmo_hit = (TMO_CYCLES < 0);
`endif

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    ctrl_setup = 1'b0;
    ctrl_in    = 1'b0;
    ctrl_out   = 1'b0;
    tx_we      = 1'b0;
    tx_data    = 8'h00;
    rx_re      = 1'b0;
    wr_re      = 1'b0;
    done       = 1'b0;
    stall_hit  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = SETUP_TOK;
      end
      SETUP_TOK: begin
        ctrl_setup = 1'b1;
        state_nx   = SETUP_DAT;
      end
      SETUP_DAT: begin
        tx_data = setup_byte;
        if (!tx_full) begin
          tx_we = 1'b1;
          if (idx == 3'd7) begin
            if (wlen_q == 16'd0) state_nx = STAT_TOK;
            else if (bm_q[7])    state_nx = DIN_TOK;
            else                 state_nx = DOUT_TOK;
          end
        end
      end
      DIN_TOK: begin
        ctrl_in  = 1'b1;
        state_nx = DIN_DAT;
      end
      DIN_DAT: begin
        if (!rx_empty) begin
          rx_re = 1'b1;
          if (pkt_left == 7'd1) state_nx = (rem == 16'd1) ? STAT_TOK : DIN_TOK;
        end
      end
      DOUT_TOK: begin
        ctrl_out = 1'b1;
        state_nx = DOUT_DAT;
      end
      DOUT_DAT: begin
        if (!tx_full) begin
          wr_re   = 1'b1;
          tx_we   = 1'b1;
          tx_data = wr_data;
          if (pkt_left == 7'd1) state_nx = (rem == 16'd1) ? STAT_TOK : DOUT_TOK;
        end
      end
      STAT_TOK: begin
        if (dir_in) ctrl_out = 1'b1;
        else        ctrl_in  = 1'b1;
        state_nx = STAT_WAIT;
      end
      STAT_WAIT: begin
        if (dev_ack) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (tmo_hit) begin
      state_nx = FIN;
      tx_we    = 1'b0;
      rx_re    = 1'b0;
      wr_re    = 1'b0;
      tx_data  = 8'h00;
    end
    // A stall overrides everything, including a byte move in the same cycle.
    if (dev_stall && (state != IDLE) && (state != FIN)) begin
      stall_hit = 1'b1;
      state_nx  = FIN;
      tx_we     = 1'b0;
      rx_re     = 1'b0;
      wr_re     = 1'b0;
      tx_data   = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bm_q     <= 8'h00;
      breq_q   <= 8'h00;
      wval_q   <= 16'h0000;
      widx_q   <= 16'h0000;
      wlen_q   <= 16'h0000;
      idx      <= 3'd0;
      rem      <= 16'd0;
      pkt_left <= 7'd0;
      status   <= 2'b00;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_valid <= rx_re;
      if (rx_re) rd_data <= rx_data;

      if (accept) begin
        bm_q   <= bmRequestType;
        breq_q <= bRequest;
        wval_q <= wValue;
        widx_q <= wIndex;
        wlen_q <= wLength;
        rem    <= wLength;
        idx    <= 3'd0;
        status <= 2'b00;
      end

      if ((state == SETUP_DAT) && tx_we) idx <= idx + 3'd1;

      if ((state == DIN_TOK) || (state == DOUT_TOK))
        pkt_left <= (rem < MAX_PKT16) ? rem[6:0] : MAX_PKT16[6:0];
      else if (rx_re || wr_re)
        pkt_left <= pkt_left - 7'd1;

      if (rx_re || wr_re) rem <= rem - 16'd1;

      if ((state_nx == FIN) && (state != FIN)) begin
        if (stall_hit)    status <= 2'b01;
        else if (tmo_hit) status <= 2'b10;
        else              status <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_usb1_ctrl_host.sv
// Directed bench for usb1_ctrl_host with a simple device-side endpoint model.
module tb_usb1_ctrl_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [7:0]  bmRequestType, bRequest;
  logic [15:0] wValue, wIndex, wLength;
  logic        ctrl_setup, ctrl_in, ctrl_out;
  logic [7:0]  tx_data;
  logic        tx_we, tx_full;
  logic [7:0]  rx_data;
  logic        rx_empty, rx_re;
  logic        dev_ack, dev_stall;
  logic [7:0]  wr_data;
  logic        wr_re;
  logic [7:0]  rd_data;
  logic        rd_valid, done;
  logic [1:0]  status;

  always #5 clk = ~clk;

  usb1_ctrl_host #(.MAX_PKT(8), .TMO_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .bmRequestType(bmRequestType), .bRequest(bRequest), .wValue(wValue),
    .wIndex(wIndex), .wLength(wLength), .ctrl_setup(ctrl_setup),
    .ctrl_in(ctrl_in), .ctrl_out(ctrl_out), .tx_data(tx_data), .tx_we(tx_we),
    .tx_full(tx_full), .rx_data(rx_data), .rx_empty(rx_empty), .rx_re(rx_re),
    .dev_ack(dev_ack), .dev_stall(dev_stall), .wr_data(wr_data), .wr_re(wr_re),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .status(status)
  );

  int checks = 0;
  int errors = 0;

  // device / user-side models
  logic [7:0] rx_mem [0:31];
  logic [7:0] out_mem [0:7];
  logic [5:0] rx_ptr, wr_ptr;
  int         rx_avail;
  logic       tb_clr;
  logic       tog_en, tog_q, tx_full_i;
  int         n_setup, n_in, n_out, n_txwe, n_rxre, n_wrre, n_done, n_bad;
  logic [7:0] tx_log [$];
  logic [7:0] rd_log [$];

  assign rx_data  = rx_mem[rx_ptr[4:0]];
  assign rx_empty = (int'(rx_ptr) >= rx_avail);
  assign wr_data  = out_mem[wr_ptr[2:0]];
  assign tx_full  = tog_en ? tog_q : tx_full_i;

  always @(negedge clk) tog_q <= tog_en ? ~tog_q : 1'b0;

  always @(posedge clk) begin
    if (tb_clr) begin
      rx_ptr <= '0; wr_ptr <= '0;
      n_setup <= 0; n_in <= 0; n_out <= 0; n_txwe <= 0;
      n_rxre <= 0; n_wrre <= 0; n_done <= 0; n_bad <= 0;
      tx_log.delete();
      rd_log.delete();
    end else begin
      if (rx_re) rx_ptr <= rx_ptr + 6'd1;
      if (wr_re) wr_ptr <= wr_ptr + 6'd1;
      if (ctrl_setup) n_setup <= n_setup + 1;
      if (ctrl_in)    n_in    <= n_in + 1;
      if (ctrl_out)   n_out   <= n_out + 1;
      if (rx_re)      n_rxre  <= n_rxre + 1;
      if (wr_re)      n_wrre  <= n_wrre + 1;
      if (done)       n_done  <= n_done + 1;
      if (tx_we) begin
        n_txwe <= n_txwe + 1;
        tx_log.push_back(tx_data);
      end
      if (rd_valid) rd_log.push_back(rd_data);
      if ($countones({ctrl_setup, ctrl_in, ctrl_out}) > 1 ||
          (req_ready && (ctrl_setup || ctrl_in || ctrl_out)))
        n_bad <= n_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_models();
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
  endtask

  function automatic logic [63:0] tx_pack(input int base, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[55:0], tx_log[base + i]};
    return v;
  endfunction

  task automatic issue(input logic [7:0] bm, input logic [7:0] br, input logic [15:0] wv,
                       input logic [15:0] wi, input logic [15:0] wl);
    bmRequestType = bm; bRequest = br; wValue = wv; wIndex = wi; wLength = wl;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output logic [1:0] st);
    got = 1'b0;
    st  = 2'bxx;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        got = 1'b1;
        st  = status;
        break;
      end
      @(negedge clk);
    end
  endtask

  bit         got;
  logic [1:0] st;
  int         sum, k;

  initial begin
    for (int i = 0; i < 32; i++) rx_mem[i] = 8'h10 + 8'(i);
    out_mem[0] = 8'hA1; out_mem[1] = 8'hA2; out_mem[2] = 8'hA3;
    for (int i = 3; i < 8; i++) out_mem[i] = 8'hEE;
    rst = 1'b1; req_valid = 1'b0; bmRequestType = '0; bRequest = '0;
    wValue = '0; wIndex = '0; wLength = '0; dev_ack = 1'b0; dev_stall = 1'b0;
    tx_full_i = 1'b0; tog_en = 1'b0; rx_avail = 0; tb_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outputs", {ctrl_setup, ctrl_in, ctrl_out, tx_we, rx_re, wr_re, rd_valid, done}, 0);
    chk("rst_data", {tx_data, rd_data, status}, 0);
    rst = 1'b0;
    clear_models();

    // GET_DESCRIPTOR, 18 bytes IN; dev_ack held high to show it is ignored early
    rx_avail = 18; dev_ack = 1'b1;
    issue(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012);
    wait_done(500, got, st);
    chk("gd_done", got, 1);
    chk("gd_status", st, 2'b00);
    @(negedge clk);
    chk("gd_setup_tok", n_setup, 1);
    chk("gd_setup_bytes", tx_pack(0, 8), 64'h8006_0001_0000_1200);
    chk("gd_txwe", n_txwe, 8);
    chk("gd_in_toks", n_in, 3);
    chk("gd_out_toks", n_out, 1);
    chk("gd_rd_count", rd_log.size(), 18);
    sum = 0;
    foreach (rd_log[i]) sum += int'(rd_log[i]);
    chk("gd_rd_sum", sum, 441);
    chk("gd_rd_first_last", {rd_log[0], rd_log[17]}, 16'h1021);
    chk("gd_ready_after", req_ready, 1);
    clear_models();

    // SET_ADDRESS, no data stage
    issue(8'h00, 8'h05, 16'h0007, 16'h0000, 16'h0000);
    wait_done(200, got, st);
    chk("sa_done", got, 1);
    chk("sa_status", st, 2'b00);
    @(negedge clk);
    chk("sa_setup_bytes", tx_pack(0, 8), 64'h0005_0700_0000_0000);
    chk("sa_toks", {8'(n_in), 8'(n_out), 8'(n_rxre)}, 24'h01_00_00);
    clear_models();

    // OUT request, 3 bytes, with tx_full toggling
    tog_en = 1'b1;
    issue(8'h40, 8'h01, 16'h0000, 16'h0000, 16'h0003);
    wait_done(300, got, st);
    chk("out_done", got, 1);
    chk("out_status", st, 2'b00);
    @(negedge clk);
    tog_en = 1'b0;
    chk("out_txwe", n_txwe, 11);
    chk("out_setup_bytes", tx_pack(0, 8), 64'h4001_0000_0000_0300);
    chk("out_data_bytes", tx_pack(8, 3), 64'hA1A2A3);
    chk("out_wrre", n_wrre, 3);
    chk("out_toks", {8'(n_in), 8'(n_out)}, 16'h0101);
    clear_models();

    // STALL during the second IN packet
    rx_avail = 18;
    issue(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012);
    for (int i = 0; i < 200 && n_rxre < 10; i++) @(negedge clk);
    chk("stall_reach", n_rxre, 10);
    dev_stall = 1'b1;
    @(negedge clk);
    dev_stall = 1'b0;
    chk("stall_done", done, 1);
    chk("stall_status", status, 2'b01);
    repeat (5) @(negedge clk);
    chk("stall_no_more_rxre", n_rxre, 10);
    chk("stall_idle", req_ready, 1);
    chk("stall_status_held", status, 2'b01);
    clear_models();

    // reset mid OUT data stage
    issue(8'h40, 8'h01, 16'h0000, 16'h0000, 16'h0003);
    for (int i = 0; i < 100 && n_wrre < 1; i++) @(negedge clk);
    chk("rst_mid_reach", n_wrre, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_outputs", {tx_we, wr_re, rx_re, done, ctrl_in, ctrl_out, ctrl_setup}, 0);
    chk("rst_mid_data", {tx_data, rd_data, status}, 0);
    repeat (20) @(negedge clk);
    chk("rst_mid_no_done", n_done, 0);
    issue(8'h00, 8'h05, 16'h0009, 16'h0000, 16'h0000);
    wait_done(200, got, st);
    chk("rst_mid_recover", {got, st}, 3'b100);
    @(negedge clk);
    clear_models();

    // status stage without dev_ack
    dev_ack = 1'b0;
    issue(8'h00, 8'h05, 16'h0007, 16'h0000, 16'h0000);
`ifdef USB1_CTRL_HOST_TIMEOUT_EN
    for (int i = 0; i < 100 && !ctrl_in; i++) @(negedge clk);
    chk("tmo_stat_tok", ctrl_in, 1);
    k = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_latency", k, 17);
    chk("tmo_status", {done, status}, 3'b110);
`else
    repeat (1000) @(negedge clk);
    chk("notmo_no_done", n_done, 0);
    dev_ack = 1'b1;
    wait_done(10, got, st);
    chk("notmo_ack_done", {got, st}, 3'b100);
`endif
    @(negedge clk);
    chk("strobe_rules", n_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
